// File: rtl/bn_phase_router.sv
// bn_phase_router: steers one 16-bit word stream to three batch-norm engines
// in phase order 0->1->2, a programmed word count per phase.
// Ports:
//   clk, rst                   clock, async active-high reset
//   start, len0..len2          batch start and per-phase word counts
//   in_data/in_valid/in_ready  upstream handshake
//   sel, out_data, out_valid   registered demux select/data, one-hot valid
//   dst_ready                  per-destination ready
//   busy, done                 batch in progress, completion pulse
module bn_phase_router #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  len0,
    input  logic [CNT_WIDTH-1:0]  len1,
    input  logic [CNT_WIDTH-1:0]  len2,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [1:0]            sel,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [2:0]            out_valid,
    input  logic [2:0]            dst_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PH0,
        S_PH1,
        S_PH2,
        S_DRAIN
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_len0;
    logic [CNT_WIDTH-1:0]  r_len1;
    logic [CNT_WIDTH-1:0]  r_len2;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic [CNT_WIDTH-1:0]  w_cur_len;
    logic [1:0]            r_sel;
    logic [1:0]            w_sel_nxt;
    logic [1:0]            w_ph;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic [2:0]            r_ov;
    logic [2:0]            w_ov_nxt;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_in_phase;
    logic                  w_drain;
    logic                  w_in_ready;
    logic                  w_load;
    logic                  w_last;
    logic                  w_start_acc;

    // Pending word leaves when its own destination is ready; sel and
    // out_valid always agree, so masking covers dst_ready[sel].
    assign w_drain     = |(r_ov & dst_ready);
    assign w_in_phase  = (r_state == S_PH0) || (r_state == S_PH1) ||
                         (r_state == S_PH2);
    assign w_in_ready  = w_in_phase && ((r_ov == 3'b000) || w_drain);
    assign w_load      = in_valid && w_in_ready;
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_last      = (r_cnt == (w_cur_len - ONE));

    always_comb begin
        w_ph      = 2'b11;
        w_cur_len = r_len2;
        unique case (r_state)
            S_PH0: begin
                w_ph      = 2'b00;
                w_cur_len = r_len0;
            end
            S_PH1: begin
                w_ph      = 2'b01;
                w_cur_len = r_len1;
            end
            S_PH2: begin
                w_ph      = 2'b10;
                w_cur_len = r_len2;
            end
            default: begin
                w_ph      = 2'b11;
                w_cur_len = r_len2;
            end
        endcase
    end

    // Next-state and count; phases with zero length are skipped.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cnt_nxt = '0;
                    if (len0 != '0)      w_state_nxt = S_PH0;
                    else if (len1 != '0) w_state_nxt = S_PH1;
                    else if (len2 != '0) w_state_nxt = S_PH2;
                    else                 w_state_nxt = S_DRAIN;
                end
            end
            S_PH0: begin
                if (w_load) begin
                    w_cnt_nxt = r_cnt + ONE;
                    if (w_last) begin
                        w_cnt_nxt = '0;
                        if (r_len1 != '0)      w_state_nxt = S_PH1;
                        else if (r_len2 != '0) w_state_nxt = S_PH2;
                        else                   w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_PH1: begin
                if (w_load) begin
                    w_cnt_nxt = r_cnt + ONE;
                    if (w_last) begin
                        w_cnt_nxt = '0;
                        if (r_len2 != '0) w_state_nxt = S_PH2;
                        else              w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_PH2: begin
                if (w_load) begin
                    w_cnt_nxt = r_cnt + ONE;
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (r_ov == 3'b000) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output register: a load replaces the word (no bubble); a drain
    // alone empties it and parks sel on "none"; data is kept.
    always_comb begin
        w_ov_nxt   = r_ov;
        w_sel_nxt  = r_sel;
        w_data_nxt = r_data;
        if (w_load) begin
            w_ov_nxt   = 3'b001 << w_ph;
            w_sel_nxt  = w_ph;
            w_data_nxt = in_data;
        end else if (w_drain) begin
            w_ov_nxt  = 3'b000;
            w_sel_nxt = 2'b11;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_len0  <= '0;
            r_len1  <= '0;
            r_len2  <= '0;
            r_ov    <= 3'b000;
            r_sel   <= 2'b11;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_start_acc) begin
                r_len0 <= len0;
                r_len1 <= len1;
                r_len2 <= len2;
            end
            r_ov   <= w_ov_nxt;
            r_sel  <= w_sel_nxt;
            r_data <= w_data_nxt;
            r_busy <= (w_state_nxt != S_IDLE);
            // Registered done: high exactly in the DRAIN cycle that
            // finds the output register empty.
            r_done <= (w_state_nxt == S_DRAIN) && (w_ov_nxt == 3'b000);
        end
    end

    assign in_ready  = w_in_ready;
    assign sel       = r_sel;
    assign out_data  = r_data;
    assign out_valid = r_ov;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_bn_phase_router.sv
// Testbench for bn_phase_router: table of batches plus hand sequences,
// checked against per-destination expected queues built from the lengths.
module tb_bn_phase_router;

    localparam int DW = 16;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] len0 = '0;
    logic [CW-1:0] len1 = '0;
    logic [CW-1:0] len2 = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    sel;
    logic [DW-1:0] out_data;
    logic [2:0]    out_valid;
    logic [2:0]    dst_ready = 3'b000;
    logic          busy;
    logic          done;

    bn_phase_router #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len0      (len0),
        .len1      (len1),
        .len2      (len2),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .dst_ready (dst_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];

    typedef struct {
        int          l0;
        int          l1;
        int          l2;
        int          vp;
        int          rp;
        int          mode;
        int          spam;
        int          exp_done;
        logic [DW-1:0] base;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_ov"}, 32'(out_valid), 32'(3'b000));
        chk({tag, "_sel"}, 32'(sel), 32'(2'b11));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_rdy"}, 32'(in_ready), 32'(0));
    endtask

    // mode 1: dest 0 not ready for cycles 3..7 (phase 0->1 boundary
    // of a 2/2/2 batch at full rate).
    task automatic run_batch(input vec_t v);
        logic [DW-1:0] words[$];
        int            total;
        int            idx;
        int            dcyc;
        int            pdest;
        bit            pacc;
        logic [DW-1:0] pdata;
        logic          exp_rdy;
        total = v.l0 + v.l1 + v.l2;
        words.delete();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < total; i++) begin
            words.push_back(v.base + DW'(i));
            if (i < v.l0)             q0.push_back(v.base + DW'(i));
            else if (i < v.l0 + v.l1) q1.push_back(v.base + DW'(i));
            else                      q2.push_back(v.base + DW'(i));
        end
        @(posedge clk); #1;
        start     = 1'b1;
        len0      = CW'(v.l0);
        len1      = CW'(v.l1);
        len2      = CW'(v.l2);
        in_valid  = 1'b0;
        dst_ready = 3'b111;
        @(posedge clk); #1;
        start = 1'b0;
        idx   = 0;
        dcyc  = -1;
        pacc  = 1'b0;
        pdata = '0;
        pdest = 0;
        for (int c = 1; c <= total * 8 + 50 && dcyc < 0; c++) begin
            len0     = CW'($urandom);
            len1     = CW'($urandom);
            len2     = CW'($urandom);
            start    = (v.spam != 0) && ($urandom_range(0, 3) == 0);
            in_valid = (idx < total) && ($urandom_range(1, 100) <= v.vp);
            in_data  = (idx < total) ? words[idx] : DW'($urandom);
            for (int k = 0; k < 3; k++)
                dst_ready[k] = ($urandom_range(1, 100) <= v.rp);
            if (v.mode == 1 && c >= 3 && c <= 7) dst_ready[0] = 1'b0;
            @(negedge clk);
            if (pacc) begin
                chk("lat_data", 32'(out_data), 32'(pdata));
                chk("lat_ov", 32'(out_valid), 32'(3'b001 << pdest));
            end
            pacc = 1'b0;
            exp_rdy = (idx < total) &&
                      ((out_valid == 3'b000) || (|(out_valid & dst_ready)));
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(1));
            if (out_valid != 3'b000) begin
                chk("ov_sel", 32'(out_valid), 32'(3'b001 << sel));
                if (|(out_valid & dst_ready)) begin
                    case (sel)
                        2'd0: if (q0.size() == 0) chk("extra0", 1, 0);
                              else chk("data0", 32'(out_data),
                                       32'(q0.pop_front()));
                        2'd1: if (q1.size() == 0) chk("extra1", 1, 0);
                              else chk("data1", 32'(out_data),
                                       32'(q1.pop_front()));
                        2'd2: if (q2.size() == 0) chk("extra2", 1, 0);
                              else chk("data2", 32'(out_data),
                                       32'(q2.pop_front()));
                        default: chk("sel_range", 32'(sel), 32'(0));
                    endcase
                end
            end else begin
                chk("empty_sel", 32'(sel), 32'(2'b11));
            end
            if (v.mode == 1 && c >= 3 && c <= 7) begin
                chk("stall_ov", 32'(out_valid), 32'(3'b001));
                chk("stall_data", 32'(out_data), 32'(words[1]));
            end
            if (total == 0) chk("zero_ov", 32'(out_valid), 32'(0));
            if (in_valid && in_ready) begin
                pacc  = 1'b1;
                pdata = in_data;
                pdest = (idx < v.l0) ? 0 : (idx < v.l0 + v.l1) ? 1 : 2;
                idx++;
            end
            if (done) dcyc = c;
            @(posedge clk); #1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (dcyc < 0) chk("done_timeout", 0, 1);
        if (v.exp_done >= 0) chk("done_cycle", 32'(dcyc), 32'(v.exp_done));
        chk("accepted", 32'(idx), 32'(total));
        chk("left", 32'(q0.size() + q1.size() + q2.size()), 0);
        @(negedge clk);
        idle_checks("after");
    endtask

    initial begin
        tbl[0] = '{3, 2, 1, 100, 100, 0, 0, 8, 16'h0001};
        tbl[1] = '{0, 4, 0, 100, 100, 0, 0, 6, 16'h0100};
        tbl[2] = '{2, 2, 2, 100, 100, 1, 0, 13, 16'h0200};
        tbl[3] = '{0, 0, 0, 100, 100, 0, 0, 1, 16'h0300};
        tbl[4] = '{1, 0, 0, 100, 100, 0, 1, 3, 16'h0400};
        tbl[5] = '{0, 0, 4095, 100, 100, 0, 0, 4097, 16'h1000};
        tbl[6] = '{7, 5, 9, 50, 50, 0, 1, -1, 16'h0500};

        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_checks("rst");
        chk("rst_data", 32'(out_data), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        idle_checks("post_rst");

        for (int i = 0; i < 7; i++) run_batch(tbl[i]);

        // Reset mid-PH1 with a dest-1 word pending.
        @(posedge clk); #1;
        start = 1'b1;
        len0 = CW'(1);
        len1 = CW'(3);
        len2 = CW'(1);
        dst_ready = 3'b111;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hA000;
        @(posedge clk); #1;
        in_data = 16'hA001;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        dst_ready = 3'b000;
        @(negedge clk);
        chk("mid_ov", 32'(out_valid), 32'(3'b010));
        chk("mid_sel", 32'(sel), 32'(2'b01));
        chk("mid_busy", 32'(busy), 32'(1));
        #1 rst = 1'b1;
        #1;
        idle_checks("mid_rst");
        chk("mid_rst_data", 32'(out_data), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        run_batch('{1, 0, 0, 100, 100, 0, 0, 3, 16'h0700});

        for (int r = 0; r < 3; r++)
            run_batch('{int'($urandom_range(0, 12)),
                        int'($urandom_range(0, 12)),
                        int'($urandom_range(0, 12)),
                        70, 60, 0, 1, -1, DW'($urandom)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
